uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   8N1 UART receiver: the consumer of the serial line driven by our UART transmitter.
//   Synchronises the asynchronous serial input and validates the start bit at mid-bit.
//   Samples 8 data bits LSB first, checks the stop bit, then presents the byte on a
//   valid/ready holding register. Sits between the external RX pin and the command/packet parser.
// PARAMETERS
//   clocks_per_bit  4  clock cycles per bit period; must be >= 2; half = clocks_per_bit/2 (floor)
// PORTS
//   clock          input   1  single system clock, all logic on posedge
//   reset          input   1  asynchronous, active-high; returns block to idle immediately
//   pin            input   1  serial line, asynchronous to clock, idles high
//   ready          input   1  consumer accepts byte_received when valid && ready
//   byte_received  output  8  last good byte; stable while valid=1
//   valid          output  1  byte_received holds an unconsumed byte
//   framing_error  output  1  one-cycle pulse: stop bit sampled low
//   overrun        output  1  one-cycle pulse: frame completed while holding register full
//   busy           output  1  high in every state except IDLE
// BEHAVIOUR
//   Reset values: byte_received=0, valid=0, framing_error=0, overrun=0, busy=0.
//   Reset also sets synchroniser flops to 1 and state to IDLE. Reset mid-frame discards the partial byte.
//   Synchroniser: 2 flops on pin; FSM sees only the second flop (s2); 2-cycle latency.
//   Counter width $clog2(clocks_per_bit)+1; cleared on every state entry and after every sample.
//   FSM states:
//    IDLE: s2==0 -> START.
//    START: at count==half-1, sample s2. If 0 -> DATA with bit_index=0. If 1 (glitch) ->
//      IDLE, no flags.
//    DATA: at count==clocks_per_bit-1, shift[bit_index]<=s2. After bit_index==7 -> STOP.
//    STOP: at count==clocks_per_bit-1, sample s2.
//      If 1 -> deliver and go to IDLE.
//      If 0 -> pulse framing_error, drop the byte, go to WAIT_HIGH.
//    WAIT_HIGH: stay until s2==1 (break/line-low tolerance), then IDLE; no false start on held-low line.
//   Timing: edge 1 = first clock edge after pin falls.
//     START is entered at edge 3.
//     Start-bit sample at edge 3+half; data bit i (0..7) at edge 3+half+(i+1)*clocks_per_bit.
//     Stop-bit sample and deliver at edge 3+half+9*clocks_per_bit.
//   Deliver, judged at the stop-sample edge:
//     If valid==0, or valid&&ready the same cycle: byte_received<=shift, valid<=1.
//     Else: overrun pulse, new byte dropped, old byte and valid unchanged.
//   Handshake: valid&&ready with no simultaneous deliver -> valid<=0 next edge; byte_received
//     keeps its value.
//   Back-to-back frames: a start bit immediately after a good stop sample is accepted; IDLE
//     re-detects within 1 cycle.
//   framing_error and overrun are never asserted together (framing error implies no deliver).
// STRUCTURE
//   Shared package (uart_pkg): state encoding (IDLE, START, DATA, STOP, WAIT_HIGH), DATA_BITS=8.
//   Transmitter and receiver both use DATA_BITS.
//   Sub-module sync_2ff: 2-flop synchroniser with reset value parameter (1 here); reusable for other async inputs.
//   Remainder (FSM, bit counter, shift register, holding register) is flat in uart_rx.
// TESTING
//   clocks_per_bit=4 unless stated. Drive pin with a behavioural 8N1 model and hold ready=1.
//   1. Send 0xA5 -> valid rises at edge 41 after fall, byte_received=0xA5, no flags.
//   2. Glitch: pin low 1 clock then high -> FSM returns to IDLE, valid stays 0, no flags, busy
//      drops by edge 6.
//   3. Send 0x3C with stop bit 0 -> framing_error pulse 1 cycle, valid stays 0; hold pin low
//      20 bit periods -> no further frames or flags; release, then send 0x81 -> receives 0x81.
//   4. ready=0: send 0x11 then 0x22 back-to-back -> byte_received=0x11, overrun pulses at
//      second stop sample, valid stays 1.
//      Raise ready -> valid drops the next edge.
//   5. Simultaneous: valid=1 (0x55); assert ready exactly at the stop-sample edge of 0x66 ->
//      byte_received=0x66, valid=1, no overrun.
//   6. Assert reset mid-DATA of 0xFF -> all outputs 0 immediately, busy=0; next frame 0x0F
//      received correctly.
//   Also run scenario 1 with clocks_per_bit=2 and 5 (odd) -> correct bytes at the computed edges.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver.
package uart_pkg;

  // Payload width of one 8N1 frame.
  localparam int DATA_BITS = 8;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// RESET_VALUE lets each user pick the line's inactive level.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic s1_q;
  logic s2_q;

  // Two back-to-back flops; only the second is safe to use downstream.
  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs before either updates, which keeps the two-stage delay.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= RESET_VALUE;
      s2_q <= RESET_VALUE;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
    end
  end

  assign sync_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, validates the start bit at
// mid-bit, shifts in 8 data bits LSB first, checks the stop bit and hands
// the byte to the consumer through a valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pin,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] byte_received,
  output logic                 valid,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF  = clocks_per_bit / 2;
  localparam int CNT_W = $clog2(clocks_per_bit) + 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(clocks_per_bit - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 s2;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .async_i(pin),
    .sync_o (s2)
  );

  // Next-state, sampling and delivery decisions.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;

    // Consumer handshake; a delivery in the same cycle overrides this below.
    if (valid_q && ready) valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (!s2) state_d = ST_START;
      end
      ST_START: begin
        if (count_q == HALF_LAST) begin
          count_d = '0;
          if (!s2) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;  // glitch shorter than half a bit
          end
        end
      end
      ST_DATA: begin
        if (count_q == BIT_LAST) begin
          count_d            = '0;
          shift_d[bit_idx_q] = s2;
          if (bit_idx_q == IDX_LAST) state_d = ST_STOP;
          else bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end
      ST_STOP: begin
        if (count_q == BIT_LAST) begin
          count_d = '0;
          if (s2) begin
            state_d = ST_IDLE;
            if (!valid_q || ready) begin
              byte_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ov_d = 1'b1;  // holding register still full: drop new byte
            end
          end else begin
            fe_d    = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // A line held low (break) must not be seen as a stream of starts.
        count_d = '0;
        if (s2) state_d = ST_IDLE;
      end
      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, shift and holding registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign byte_received = byte_q;
  assign valid         = valid_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
